// File: rtl/alu_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter_if
// Purpose  : Requester, shared-ALU and response signals of alu_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [2:0] req0_op;
    logic [2:0] req1_op;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req1_a;
    logic [3:0] req1_b;

    logic [2:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;

    logic       rsp_valid;
    logic       rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_overflow;

    logic [7:0] grant_cnt0;
    logic [7:0] grant_cnt1;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req0_b, req1_a, req1_b,
        input  alu_result, alu_carry, alu_overflow,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
        output grant_cnt0, grant_cnt1
    );

    // Requesters plus the shared ALU
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req0_b, req1_a, req1_b,
        output alu_result, alu_carry, alu_overflow,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
        input  grant_cnt0, grant_cnt1
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one combinational 4-bit ALU between
//            two requesters; IDLE -> ISSUE -> RESP, one response pulse per op.
//            Define ALU_ARBITER_GRANT_CNT_EN to build saturating grant counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter (
    input  wire          clk,
    input  wire          rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    // 0: req0 wins a tie, 1: req1 wins a tie
    logic       r_prio;

    logic [2:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_id;

    logic       r_rsp_id;
    logic [3:0] r_rsp_result;
    logic       r_rsp_carry;
    logic       r_rsp_overflow;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_accept;
    logic       w_capture;

    //--------------------------------------------------------------------------
    // Next-state, arbitration and capture strobe
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !r_prio)) begin
                    w_grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    w_grant1 = 1'b1;
                end
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_grant0 | w_grant1;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Priority pointer and operand latch
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
            r_op   <= 3'd0;
            r_a    <= 4'd0;
            r_b    <= 4'd0;
            r_id   <= 1'b0;
        end else if (w_accept) begin
            // The requester just served loses the next tie
            r_prio <= w_grant0;
            r_id   <= w_grant1;
            r_op   <= w_grant1 ? bus.req1_op : bus.req0_op;
            r_a    <= w_grant1 ? bus.req1_a  : bus.req0_a;
            r_b    <= w_grant1 ? bus.req1_b  : bus.req0_b;
        end
    end

    //--------------------------------------------------------------------------
    // Response capture; data holds until the next ISSUE
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= 4'd0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else if (w_capture) begin
            r_rsp_id       <= r_id;
            r_rsp_result   <= bus.alu_result;
            r_rsp_carry    <= bus.alu_carry;
            r_rsp_overflow <= bus.alu_overflow;
        end
    end

    //--------------------------------------------------------------------------
    // Optional grant counters
    //--------------------------------------------------------------------------
`ifdef ALU_ARBITER_GRANT_CNT_EN
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    logic [7:0] r_grant_cnt0;
    logic [7:0] r_grant_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt0 <= 8'd0;
            r_grant_cnt1 <= 8'd0;
        end else begin
            if (w_grant0 && (r_grant_cnt0 != c_CNT_MAX)) begin
                r_grant_cnt0 <= r_grant_cnt0 + 8'd1;
            end
            if (w_grant1 && (r_grant_cnt1 != c_CNT_MAX)) begin
                r_grant_cnt1 <= r_grant_cnt1 + 8'd1;
            end
        end
    end

    assign bus.grant_cnt0 = r_grant_cnt0;
    assign bus.grant_cnt1 = r_grant_cnt1;
`else
    assign bus.grant_cnt0 = 8'd0;
    assign bus.grant_cnt1 = 8'd0;
`endif

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.req0_ready   = w_grant0;
    assign bus.req1_ready   = w_grant1;

    assign bus.alu_op       = r_op;
    assign bus.alu_a        = r_a;
    assign bus.alu_b        = r_b;

    assign bus.rsp_valid    = (r_state == ST_RESP);
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_carry    = r_rsp_carry;
    assign bus.rsp_overflow = r_rsp_overflow;

endmodule

`default_nettype wire
